divider_seq: RTL

- Iterative unsigned restoring divider that produces quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Uses a single addern instance in subtract mode (inverted divisor, cin=1); the adder carry-out is the no-borrow flag.
- Sits beside the combinational adder datapath as the ALU's multi-cycle divide unit, with a start/busy/done handshake to the sequencer.

---
 rtl/divider_seq_pkg.sv | 14 +
 rtl/divider_seq_addern.sv | 14 +
 rtl/divider_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_seq_addern.sv
// Generic N-bit ripple adder with carry in/out, reused here as a trial subtractor.
module addern #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t     state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH:0]   next_r;
    logic [WIDTH-1:0] next_q;

    // Working at WIDTH+1 bits keeps divisors above half range from wrapping.
    assign shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    addern #(.N(WIDTH + 1)) u_trial_sub (
        .a    (shifted),
        .b    (~{1'b0, d_reg}),
        .cin  (1'b1),
        .sum  (trial),
        .cout (no_borrow)
    );

    assign next_r = no_borrow ? trial : shifted;
    assign next_q = {q_reg[WIDTH-2:0], no_borrow};

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        q_reg    <= dividend;
                        d_reg    <= divisor;
                        r_reg    <= '0;
                        count    <= CW'(WIDTH);
                        div_zero <= (divisor == '0);
                        state    <= ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_reg <= next_r;
                    q_reg <= next_q;
                    count <= count - CW'(1);
                    // Results are published only on the final iteration so they stay stable during CALC.
                    if (count == CW'(1)) begin
                        state     <= ST_DONE;
                        quotient  <= next_q;
                        remainder <= next_r[WIDTH-1:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
